// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-to-decode instruction handshake
interface fetch_unit_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_pc;

   modport master (output instr_valid, output instr, output instr_pc, input instr_ready);
   modport slave  (input instr_valid, input instr, input instr_pc, output instr_ready);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: registered PC, one-cycle memory, credit-limited FIFO
module fetch_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int unsigned DEPTH        = 2
) (
   input  logic         clock,
   input  logic         reset,
   output logic [15:0]  program_counter,
   input  logic [15:0]  current_instruction,
   input  logic         fetch_enable,
   input  logic         redirect_valid,
   input  logic [15:0]  redirect_target,
   fetch_unit_if.master dec
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1) + 1;

   logic [15:0]   word_q [DEPTH];
   logic [15:0]   pc_q   [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          inflight;
   logic [15:0]   inflight_pc;
   logic          pop;
   logic          push;
   logic          issue;
   logic [CW:0]   credit;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign dec.instr_valid = (count != '0);
   assign dec.instr       = word_q[rd_ptr];
   assign dec.instr_pc    = pc_q[rd_ptr];

   assign pop  = dec.instr_valid && dec.instr_ready;
   assign push = inflight && !redirect_valid;

   // Slots already promised (stored + in flight) after this cycle's pop; a new fetch
   // is only launched when its word is guaranteed a FIFO slot on return.
   assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue  = !redirect_valid && fetch_enable && (credit < (CW+1)'(DEPTH));

   always_ff @(posedge clock) begin
      if (reset) begin
         program_counter <= RESET_VECTOR;
         inflight        <= 1'b0;
         inflight_pc     <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            word_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (redirect_valid) begin
         program_counter <= redirect_target;
         inflight        <= 1'b0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         count           <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc     <= program_counter;
            program_counter <= program_counter + 16'd1;
         end
         if (push) begin
            word_q[wr_ptr] <= current_instruction;
            pc_q[wr_ptr]   <= inflight_pc;
            wr_ptr         <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (!push && pop) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && push && !pop) begin
         assert (count < CW'(DEPTH));
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a sequential-address model
module tb_fetch_unit;
   localparam logic [15:0] RV    = 16'h0000;
   localparam int          DEPTH = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] program_counter;
   logic [15:0] current_instruction;
   logic        fetch_enable = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_target = 16'h0;
   int          n_vec = 0;
   int          n_miss = 0;
   logic [15:0] exp_pc = RV;
   logic [15:0] pc_hold;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
      .clock               (clock),
      .reset               (reset),
      .program_counter     (program_counter),
      .current_instruction (current_instruction),
      .fetch_enable        (fetch_enable),
      .redirect_valid      (redirect_valid),
      .redirect_target     (redirect_target),
      .dec                 (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   // One-cycle read memory: address sampled at an edge, data valid until the next edge
   always @(posedge clock) current_instruction <= mem_word(program_counter);

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle; any word decode accepts must be the next address on the current path
   task automatic cycle(input logic rdy, input logic fe, input logic rv, input logic [15:0] rt);
      bus.instr_ready = rdy;
      fetch_enable    = fe;
      redirect_valid  = rv;
      redirect_target = rt;
      if (bus.instr_valid && rdy) begin
         check16("pop_pc", bus.instr_pc, exp_pc);
         check16("pop_instr", bus.instr, mem_word(exp_pc));
         exp_pc = exp_pc + 16'd1;
      end
      if (rv) exp_pc = rt;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset           = 1'b1;
      bus.instr_ready = 1'b0;
      fetch_enable    = 1'b0;
      redirect_valid  = 1'b0;
      repeat (n) @(posedge clock);
      #1;
      reset  = 1'b0;
      exp_pc = RV;
      check16("rst_valid", bus.instr_valid, 16'd0);
      check16("rst_instr", bus.instr, 16'd0);
      check16("rst_instr_pc", bus.instr_pc, 16'd0);
      check16("rst_pc", program_counter, RV);
   endtask

   task automatic restart_seq();
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      check16("start_valid_e1", bus.instr_valid, 16'd0);
      check16("start_pc_e1", program_counter, 16'(RV + 16'd1));
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      check16("start_valid_e2", bus.instr_valid, 16'd1);
      check16("start_head_e2", bus.instr_pc, RV);
      for (int i = 0; i < 20; i++) begin
         check16("stream_valid", bus.instr_valid, 16'd1);
         cycle(1'b1, 1'b1, 1'b0, 16'h0);
      end
   endtask

   initial begin
      bus.instr_ready = 1'b0;
      do_reset(3);

      // Scenario 1: back-to-back stream from reset
      restart_seq();

      // Scenario 2: decode backpressure for 6 cycles
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
         check16("stall_valid", bus.instr_valid, 16'd1);
         check16("stall_head_pc", bus.instr_pc, exp_pc);
         check16("stall_head_instr", bus.instr, mem_word(exp_pc));
      end
      check16("stall_pc_full", program_counter, 16'(exp_pc + 16'(DEPTH)));
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);

      // Scenario 3: redirect with a fetch in flight and decode stalled
      cycle(1'b0, 1'b1, 1'b1, 16'h1234);
      check16("redir_valid_e0", bus.instr_valid, 16'd0);
      check16("redir_pc_e0", program_counter, 16'h1234);
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      check16("redir_valid_e1", bus.instr_valid, 16'd0);
      check16("redir_pc_e1", program_counter, 16'h1235);
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      check16("redir_valid_e2", bus.instr_valid, 16'd1);
      check16("redir_head_e2", bus.instr_pc, 16'h1234);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);

      // Scenario 4: address wrap, redirect while popping
      cycle(1'b1, 1'b1, 1'b1, 16'hFFFE);
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      check16("wrap_head0", bus.instr_pc, 16'hFFFE);
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      check16("wrap_head2", bus.instr_pc, 16'h0000);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);

      // Scenario 5: reset with the FIFO full, then identical restart
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
      do_reset(1);
      restart_seq();

      // Scenario 6: fetch disabled while decode keeps draining
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      pc_hold = program_counter;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 16'h0);
         check16("fe_off_pc_hold", program_counter, pc_hold);
      end
      check16("fe_off_valid", bus.instr_valid, 16'd0);
      check16("fe_off_pc_next", program_counter, exp_pc);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);

      // Randomized traffic: backpressure, fetch gating and redirects
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) < 17),
               1'($urandom_range(0, 19) == 0), 16'($urandom));
      end
      begin
         int waited = 0;
         while (!bus.instr_valid && waited < 6) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0);
            waited++;
         end
         check16("live_valid", bus.instr_valid, 16'd1);
         check16("live_head_pc", bus.instr_pc, exp_pc);
      end
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
